// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: per-opcode state sequencing, memory-ready stalls,
// illegal-opcode flagging and a retired-instruction counter.
module mc_ctrl_fsm #(
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 32,
  parameter int MEM_WAIT = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwrite_cond,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   retired,
  output logic [3:0]         state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b110;
  localparam logic [2:0] ALU_NO_USE = 3'b000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  function automatic logic [ALUOP_W-1:0] alu_ext(input logic [2:0] code);
    return ALUOP_W'(code);
  endfunction

  state_t state_q, state_d;
  logic   ready;
  logic   retire;
  logic   illegal_d;

  logic   pcw_d, pcwc_d, memread_d, memwrite_d, irwrite_d, regwrite_d;

  assign ready = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      // op can only change here if the IR was disturbed; abandon rather than guess
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:  if (ready) state_d = S_MEMWB;
      S_MEMWR: begin
        if (ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcw_d      = 1'b0;
    pcwc_d     = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    irwrite_d  = 1'b0;
    regwrite_d = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = alu_ext(ALU_NO_USE);
    case (state_q)
      S_FETCH: begin
        memread_d = 1'b1;
        alusrcb   = 2'b01;
        aluop     = alu_ext(ALU_ADD);
        irwrite_d = ready;
        pcw_d     = ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        aluop   = alu_ext(ALU_ADD);
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = alu_ext(ALU_ADD);
      end
      S_MEMRD: begin
        memread_d = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        regwrite_d = 1'b1;
        memtoreg   = 1'b1;
      end
      // the write request is held for the whole stall, not just the ready cycle
      S_MEMWR: begin
        memwrite_d = 1'b1;
        iord       = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = alu_ext(ALU_NO_USE);
      end
      S_ALUWB: begin
        regwrite_d = 1'b1;
        regdst     = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = alu_ext(ALU_SUB);
        pcwc_d  = 1'b1;
        pcsrc   = 2'b01;
      end
      S_ADDIWB: regwrite_d = 1'b1;
      S_JUMP: begin
        pcw_d = 1'b1;
        pcsrc = 2'b10;
      end
      default: ;
    endcase
  end

  // strobes are suppressed combinationally for the whole time resetn is low
  assign pcwrite      = resetn & pcw_d;
  assign pcwrite_cond = resetn & pcwc_d;
  assign memread      = resetn & memread_d;
  assign memwrite     = resetn & memwrite_d;
  assign irwrite      = resetn & irwrite_d;
  assign regwrite     = resetn & regwrite_d;
  assign illegal_op   = resetn & illegal_d;
  assign state        = state_q;

endmodule
